audio_i2s_tx: RTL and testbench

//  Consumes the four signed 16-bit voice channels and the sample_clk strobe from core_soc.

---
 rtl/audio_pkg.sv | 43 ++++
 rtl/audio_mix2.sv | 21 ++
 rtl/audio_i2s_tx.sv | 191 +++++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared state encoding, frame geometry and bit-level helpers for the I2S transmitter.
package audio_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int LR_BIT     = $clog2(SLOT_BITS);
  localparam int IDX_W      = $clog2(SAMPLE_W);

  localparam logic [LR_BIT-1:0] K_LAST = LR_BIT'(SAMPLE_W);

  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] s);
    logic [SAMPLE_W-1:0] r;
    r = s[SAMPLE_W-1:0];
    // The top two bits disagree only when the 17-bit sum left the 16-bit range.
    if (!s[SAMPLE_W] && s[SAMPLE_W-1]) begin
      r = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (s[SAMPLE_W] && !s[SAMPLE_W-1]) begin
      r = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end
    return r;
  endfunction

  function automatic logic slot_bit(input logic [2*SAMPLE_W-1:0] pair,
                                    input logic [BIT_W-1:0]      bit_cnt);
    logic [SAMPLE_W-1:0] word;
    logic [LR_BIT-1:0]   k;
    logic [IDX_W-1:0]    idx;
    logic                b;
    word = bit_cnt[LR_BIT] ? pair[SAMPLE_W-1:0] : pair[2*SAMPLE_W-1:SAMPLE_W];
    k    = bit_cnt[LR_BIT-1:0];
    idx  = IDX_W'(K_LAST - k);
    b    = 1'b0;
    if (k != '0 && k <= K_LAST) begin
      b = word[idx];
    end
    return b;
  endfunction

endpackage

// File: rtl/audio_mix2.sv
// Two-input signed voice mixer; saturating when AUDIO_I2S_SATURATE_EN is defined,
// otherwise the 17-bit sum is arithmetically halved so it can never clip.
module audio_mix2
  import audio_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a_i,
  input  logic [SAMPLE_W-1:0] b_i,
  output logic [SAMPLE_W-1:0] mix_o
);

  logic signed [SAMPLE_W:0] sum;

  assign sum = $signed({a_i[SAMPLE_W-1], a_i}) + $signed({b_i[SAMPLE_W-1], b_i});

`ifdef AUDIO_I2S_SATURATE_EN
  assign mix_o = sat16(sum);
`else
  assign mix_o = SAMPLE_W'(sum >>> 1);
`endif

endmodule

// File: rtl/audio_i2s_tx.sv
// Four-voice stereo mixer feeding a double-buffered I2S serialiser.
// Mix mode is selected by AUDIO_I2S_SATURATE_EN (see audio_mix2).
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                sample_clk_i,
  input  logic [SAMPLE_W-1:0] channel_a_i,
  input  logic [SAMPLE_W-1:0] channel_b_i,
  input  logic [SAMPLE_W-1:0] channel_c_i,
  input  logic [SAMPLE_W-1:0] channel_d_i,
  output logic                i2s_bclk_o,
  output logic                i2s_lrclk_o,
  output logic                i2s_sdata_o,
  output logic                frame_start_o,
  output logic                overrun_o,
  output logic                underrun_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    sdata_q, sdata_d;
  logic [2*SAMPLE_W-1:0]   shift_q, shift_d;
  logic [2*SAMPLE_W-1:0]   hold_q, hold_d;
  logic                    fresh_q, fresh_d;
  logic                    frame_start_q, frame_start_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    samp_prev_q, samp_prev_d;
  logic                    samp_stb;
  logic                    consume;

  logic [1:0][SAMPLE_W-1:0] mix_x, mix_y, mix_out;

  genvar gi;

  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = sample_clk_i;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign samp_prev_d = sync_q[SYNC_STAGES-1];
  assign samp_stb    = sync_q[SYNC_STAGES-1] & ~samp_prev_q;

  // Index 0 is the left mix (A+C), index 1 the right mix (B+D).
  assign mix_x = {channel_b_i, channel_a_i};
  assign mix_y = {channel_d_i, channel_c_i};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_mix
      audio_mix2 u_mix (
        .a_i   (mix_x[gi]),
        .b_i   (mix_y[gi]),
        .mix_o (mix_out[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    bclk_d        = bclk_q;
    bit_d         = bit_q;
    sdata_d       = sdata_q;
    shift_d       = shift_q;
    hold_d        = hold_q;
    fresh_d       = fresh_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    underrun_d    = underrun_q;
    consume       = 1'b0;

    case (state_q)
      IDLE: begin
        div_d   = '0;
        bclk_d  = 1'b0;
        bit_d   = '0;
        sdata_d = 1'b0;
        if (enable_i) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (fresh_q) begin
          consume       = 1'b1;
          shift_d       = hold_q;
          frame_start_d = 1'b1;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // Everything serial advances on the BCLK falling edge.
          if (bclk_q) begin
            bit_d   = bit_q + BIT_W'(1);
            sdata_d = slot_bit(shift_q, bit_d);
            if (bit_q == FRAME_LAST) begin
              if (!enable_i) begin
                state_d = IDLE;
              end else begin
                frame_start_d = 1'b1;
                if (fresh_q) begin
                  consume = 1'b1;
                  shift_d = hold_q;
                end else begin
                  underrun_d = 1'b1;
                end
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      fresh_d = 1'b0;
    end
    // A load in the same cycle takes the old holding value, so no overrun then.
    if (samp_stb) begin
      hold_d  = {mix_out[0], mix_out[1]};
      fresh_d = 1'b1;
      if (fresh_q && !consume) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      div_q         <= '0;
      bclk_q        <= 1'b0;
      bit_q         <= '0;
      sdata_q       <= 1'b0;
      shift_q       <= '0;
      hold_q        <= '0;
      fresh_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      sync_q        <= '0;
      samp_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      bit_q         <= bit_d;
      sdata_q       <= sdata_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      fresh_q       <= fresh_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      sync_q        <= sync_d;
      samp_prev_q   <= samp_prev_d;
    end
  end

  assign i2s_bclk_o    = bclk_q;
  assign i2s_lrclk_o   = bit_q[LR_BIT];
  assign i2s_sdata_o   = sdata_q;
  assign frame_start_o = frame_start_q;
  assign overrun_o     = overrun_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed + randomized bench for audio_i2s_tx: an I2S receiver decodes the serial
// stream into stereo words that are compared with arithmetic mixes of the driven voices.
module tb_audio_i2s_tx;

  localparam int BCLK_DIV    = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FRAME_CYC   = 64 * 2 * BCLK_DIV;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        sample_clk_i = 1'b0;
  logic [15:0] channel_a_i = '0;
  logic [15:0] channel_b_i = '0;
  logic [15:0] channel_c_i = '0;
  logic [15:0] channel_d_i = '0;
  logic        i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o;
  logic        frame_start_o, overrun_o, underrun_o;

  always #5 clk_i = ~clk_i;

  audio_i2s_tx #(
    .BCLK_DIV    (BCLK_DIV),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .sample_clk_i  (sample_clk_i),
    .channel_a_i   (channel_a_i),
    .channel_b_i   (channel_b_i),
    .channel_c_i   (channel_c_i),
    .channel_d_i   (channel_d_i),
    .i2s_bclk_o    (i2s_bclk_o),
    .i2s_lrclk_o   (i2s_lrclk_o),
    .i2s_sdata_o   (i2s_sdata_o),
    .frame_start_o (frame_start_o),
    .overrun_o     (overrun_o),
    .underrun_o    (underrun_o)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Receiver state
  int          fs_cnt = 0;
  int          stray_bits = 0;
  int          mon_pos = 0;
  int          gap = 1000;
  logic        mon_lr = 1'b1;
  logic        bclk_prev = 1'b0;
  logic [15:0] rx_word = '0;
  logic [15:0] rx_left = '0;
  logic [31:0] rx_q[$];

  // Frame-level reference: each voice pair is plain integer arithmetic.
  function automatic logic [15:0] mix_ref(input logic [15:0] x, input logic [15:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
`ifdef AUDIO_I2S_SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
`else
    return 16'(s >>> 1);
`endif
  endfunction

  function automatic logic [31:0] pair_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
    return {mix_ref(a, c), mix_ref(b, d)};
  endfunction

  // I2S receiver: samples on BCLK rising edges; MSB one bit after each LRCLK change.
  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (frame_start_o) fs_cnt++;
      gap++;
      if (i2s_bclk_o && !bclk_prev) begin
        if (gap > 4 * BCLK_DIV) mon_lr = 1'b1;
        gap = 0;
        if (i2s_lrclk_o != mon_lr) mon_pos = 0;
        else mon_pos++;
        mon_lr = i2s_lrclk_o;
        if (mon_pos >= 1 && mon_pos <= 16) rx_word = {rx_word[14:0], i2s_sdata_o};
        else if (i2s_sdata_o) stray_bits++;
        if (mon_pos == 16) begin
          if (!i2s_lrclk_o) rx_left = rx_word;
          else rx_q.push_back({rx_left, rx_word});
        end
      end
      bclk_prev = i2s_bclk_o;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_sample(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
    @(negedge clk_i);
    channel_a_i  = a;
    channel_b_i  = b;
    channel_c_i  = c;
    channel_d_i  = d;
    sample_clk_i = 1'b1;
    tick(4);
    sample_clk_i = 1'b0;
    tick(4);
    $display("sample  A=%h B=%h C=%h D=%h -> expect L=%h R=%h", a, b, c, d, mix_ref(a, c), mix_ref(b, d));
  endtask

  task automatic expect_fs(input string tag, input int base);
    int n = 0;
    while (fs_cnt <= base && n < 2 * FRAME_CYC) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(fs_cnt > base), 32'd1);
  endtask

  task automatic expect_pair(input string tag, input logic [31:0] exp_v);
    logic [31:0] got = 'x;
    int n = 0;
    while (rx_q.size() == 0 && n < 2 * FRAME_CYC) begin
      @(negedge clk_i);
      n++;
    end
    if (rx_q.size() != 0) got = rx_q.pop_front();
    $display("frame   %s: L=%h R=%h", tag, got[31:16], got[15:0]);
    check(tag, got, exp_v);
  endtask

  task automatic wait_bit(input string tag, input int target);
    int n = 0;
    while (((mon_lr ? 32 : 0) + mon_pos) != target && n < 2 * FRAME_CYC) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'((mon_lr ? 32 : 0) + mon_pos), 32'(target));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bclk"},  32'(i2s_bclk_o),    32'd0);
    check({tag, "_lrclk"}, 32'(i2s_lrclk_o),   32'd0);
    check({tag, "_sdata"}, 32'(i2s_sdata_o),   32'd0);
    check({tag, "_fs"},    32'(frame_start_o), 32'd0);
    check({tag, "_ovr"},   32'(overrun_o),     32'd0);
    check({tag, "_udr"},   32'(underrun_o),    32'd0);
  endtask

  initial begin : stim
    logic [15:0] ta[4], tb_v[4], tc[4], td[4];
    logic [15:0] a, b, c, d;
    logic [31:0] cur, nxt;
    int base;

    ta[0] = 16'h7000; tb_v[0] = 16'h8000; tc[0] = 16'h7000; td[0] = 16'h8000;
    ta[1] = 16'h7FFF; tb_v[1] = 16'h8001; tc[1] = 16'h0001; td[1] = 16'hFFFF;
    ta[2] = 16'hFFFF; tb_v[2] = 16'h0003; tc[2] = 16'h0000; td[2] = 16'h0000;
    ta[3] = 16'h8000; tb_v[3] = 16'h7FFF; tc[3] = 16'hFFFF; td[3] = 16'h0001;

    // Reset state
    rst_i = 1'b0;
    tick(4);
    check_outputs_zero("reset");
    rst_i = 1'b1;
    tick(2);

    // Enabled but no sample yet: nothing may be clocked out
    enable_i = 1'b1;
    tick(40);
    check("sync_bclk_idle", 32'(i2s_bclk_o), 32'd0);
    check("sync_no_frame", 32'(fs_cnt), 32'd0);

    // First frame
    base = fs_cnt;
    send_sample(16'h1234, 16'h0F0F, 16'h0000, 16'h0000);
    cur = pair_ref(16'h1234, 16'h0F0F, 16'h0000, 16'h0000);
    expect_fs("first_fs", base);

    // Steady stream: one sample per frame, directed corners then random
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        a = ta[i]; b = tb_v[i]; c = tc[i]; d = td[i];
      end else begin
        a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      end
      send_sample(a, b, c, d);
      nxt = pair_ref(a, b, c, d);
      expect_pair($sformatf("stream%0d", i), cur);
      cur = nxt;
      base = fs_cnt;
      expect_fs($sformatf("stream_fs%0d", i), base);
    end

    // Overrun: two samples inside one frame, the newer one is sent
    check("ovr_before", 32'(overrun_o), 32'd0);
    send_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send_sample(a, b, c, d);
    tick(2);
    check("ovr_set", 32'(overrun_o), 32'd1);
    expect_pair("ovr_current", cur);
    cur = pair_ref(a, b, c, d);
    base = fs_cnt;
    expect_fs("ovr_fs", base);
    expect_pair("ovr_newer", cur);

    // Underrun: no new sample for two frames, previous pair replayed
    check("udr_before", 32'(underrun_o), 32'd0);
    base = fs_cnt;
    expect_fs("udr_fs1", base);
    check("udr_set", 32'(underrun_o), 32'd1);
    expect_pair("udr_replay1", cur);
    base = fs_cnt;
    expect_fs("udr_fs2", base);
    expect_pair("udr_replay2", cur);

    // Disable at bit 20: frame runs to bit 63, then everything idles low
    base = fs_cnt;
    expect_fs("dis_fs", base);
    wait_bit("dis_reach20", 20);
    enable_i = 1'b0;
    expect_pair("dis_pair", cur);
    tick(3 * BCLK_DIV * 16 + 40);
    check("dis_last_bit", 32'((mon_lr ? 32 : 0) + mon_pos), 32'd63);
    check("dis_bclk", 32'(i2s_bclk_o), 32'd0);
    check("dis_lrclk", 32'(i2s_lrclk_o), 32'd0);
    check("dis_sdata", 32'(i2s_sdata_o), 32'd0);
    base = fs_cnt;
    tick(FRAME_CYC);
    check("idle_no_frame", 32'(fs_cnt), 32'(base));
    check("idle_bclk", 32'(i2s_bclk_o), 32'd0);

    // Reset mid-frame at bit 40
    enable_i = 1'b1;
    base = fs_cnt;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send_sample(a, b, c, d);
    expect_fs("re_fs", base);
    wait_bit("rst_reach40", 40);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_outputs_zero("midrst");
    rst_i = 1'b1;
    rx_q.delete();
    base = fs_cnt;
    tick(FRAME_CYC);
    check("post_rst_no_frame", 32'(fs_cnt), 32'(base));
    check("post_rst_bclk", 32'(i2s_bclk_o), 32'd0);

    // Fresh sample restarts the stream
    base = fs_cnt;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
    send_sample(a, b, c, d);
    expect_fs("restart_fs", base);
    expect_pair("restart_pair", pair_ref(a, b, c, d));
    check("restart_ovr", 32'(overrun_o), 32'd0);
    check("restart_udr", 32'(underrun_o), 32'd0);
    check("stray_slot_bits", 32'(stray_bits), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
